// File: rtl/fetch_unit.sv
// Instruction fetch stage: PC register, IF/ID pipeline register and a RUN/END
// sequencer that stops fetching once the program space is exhausted.
module fetch_unit #(
  parameter logic [31:0] RESET_PC   = 32'h0000_0000,
  parameter int unsigned ADDR_LIMIT = 1024
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        freeze,
  input  logic        branch_taken,
  input  logic [31:0] branch_addr,
  output logic [31:0] imem_address,
  input  logic [31:0] imem_instruction,
  output logic [31:0] if_pc,
  output logic [31:0] if_instruction,
  output logic        if_valid
);

  localparam logic [31:0] LIMIT = 32'(ADDR_LIMIT);

  typedef enum logic {S_RUN, S_END} state_e;

  state_e      state_q, state_d;
  logic [31:0] pc_q, pc_d;
  logic [31:0] if_pc_q, if_pc_d;
  logic [31:0] if_instr_q, if_instr_d;
  logic        if_valid_q, if_valid_d;

  logic [31:0] pc_plus4;
  logic [31:0] target;

  assign pc_plus4 = pc_q + 32'd4;
  assign target   = {branch_addr[31:2], 2'b00};

  always_comb begin
    // NOTE: every next-state value gets a hold default first so no path
    // through the branches below leaves a signal unassigned (no latches).
    state_d    = state_q;
    pc_d       = pc_q;
    if_pc_d    = if_pc_q;
    if_instr_d = if_instr_q;
    if_valid_d = if_valid_q;

    if (branch_taken) begin
      // Redirect wins over freeze; the wrong-path fetch is squashed.
      pc_d       = target;
      if_pc_d    = '0;
      if_instr_d = '0;
      if_valid_d = 1'b0;
      state_d    = (target < LIMIT) ? S_RUN : S_END;
    end else if (!freeze) begin
      unique case (state_q)
        S_RUN: begin
          if_pc_d    = pc_plus4;
          if_instr_d = imem_instruction;
          if_valid_d = 1'b1;
          if (pc_plus4 >= LIMIT) begin
            pc_d    = LIMIT;
            state_d = S_END;
          end else begin
            pc_d = pc_plus4;
          end
        end
        S_END: begin
          if_pc_d    = '0;
          if_instr_d = '0;
          if_valid_d = 1'b0;
        end
        default: state_d = S_RUN;
      endcase
    end
  end

  // Reset has priority over everything, so the memory word is never captured
  // while rst is high.
  always_ff @(posedge clk) begin
    // NOTE: sequential state uses non-blocking assignments so all registers
    // update together from the values present before the edge.
    if (rst) begin
      state_q    <= S_RUN;
      pc_q       <= RESET_PC;
      if_pc_q    <= '0;
      if_instr_q <= '0;
      if_valid_q <= 1'b0;
    end else begin
      state_q    <= state_d;
      pc_q       <= pc_d;
      if_pc_q    <= if_pc_d;
      if_instr_q <= if_instr_d;
      if_valid_q <= if_valid_d;
    end
  end

  assign imem_address   = pc_q;
  assign if_pc          = if_pc_q;
  assign if_instruction = if_instr_q;
  assign if_valid       = if_valid_q;

endmodule

// File: doc/fetch_unit.md
FETCH_UNIT -- requirements
Module: fetch_unit

Interface
REQ-001 Parameter RESET_PC, default 32'h0000_0000: byte address loaded into PC on reset.
REQ-002 Parameter ADDR_LIMIT, default 1024: size of instruction memory in bytes; first address outside program space.
REQ-003 clk  input  1  single clock; all state updates on rising edge.
REQ-004 rst  input  1  synchronous, active-high reset.
REQ-005 freeze  input  1  hazard stall from decode; holds PC and IF/ID register.
REQ-006 branch_taken  input  1  redirect request from execute stage.
REQ-007 branch_addr  input  32  redirect target byte address.
REQ-008 imem_address  output  32  byte address driven to instruction memory; combinational copy of PC.
REQ-009 imem_instruction  input  32  instruction returned combinationally by memory for imem_address, big-endian byte order.
REQ-010 if_pc  output  32  registered PC+4 of the instruction held in IF/ID.
REQ-011 if_instruction  output  32  registered instruction word (IF/ID).
REQ-012 if_valid  output  1  registered; 1 = IF/ID holds a real fetched instruction.

Function
REQ-013 Internal state: PC register (32b), IF/ID register {if_pc, if_instruction, if_valid}, 2-state FSM {RUN, END}.
REQ-014 imem_address SHALL equal PC in every cycle, including END.
REQ-015 RUN, no freeze, no branch: at edge, IF/ID <= {PC+4, imem_instruction, 1}; PC <= PC+4.
REQ-016 Fetch latency: instruction at address A appears on if_instruction exactly one cycle after imem_address = A.
REQ-017 freeze=1, branch_taken=0: PC, IF/ID and FSM state SHALL hold unchanged.
REQ-018 branch_taken=1: PC <= {branch_addr[31:2], 2'b00}; IF/ID <= {0, 0, 0} (flush of wrong-path fetch); FSM <= RUN if aligned target < ADDR_LIMIT, else END.
REQ-019 branch_taken SHALL take priority over freeze when both asserted in the same cycle.
REQ-020 RUN -> END when PC+4 >= ADDR_LIMIT on a non-frozen, non-branch advance; IF/ID still captures the last instruction (valid=1); PC <= ADDR_LIMIT.
REQ-021 END: PC holds; IF/ID <= {0, 0, 0} each cycle (bubbles); leaves END only via branch_taken to an in-range target.
REQ-022 PC arithmetic is 32-bit modulo 2^32; no carry out.
REQ-023 if_instruction = 0 with if_valid = 0 SHALL be treated downstream as a bubble; if_valid is never 1 for a flushed or END slot.
REQ-024 imem_instruction SHALL NOT be sampled while rst=1.

Reset
REQ-025 rst=1 at an edge: PC <= RESET_PC, FSM <= RUN, if_pc <= 0, if_instruction <= 0, if_valid <= 0; overrides freeze and branch_taken.
REQ-026 rst asserted mid-run SHALL discard the IF/ID contents; first valid output is the instruction at RESET_PC, one cycle after rst deasserts.

Verification
REQ-027 Free run from reset, memory preloaded: imem_address 0,4,8,12 on successive cycles; if_pc 4,8,12 with if_valid=1 starting the cycle after address 0.
REQ-028 freeze=1 for 2 cycles while imem_address=8: imem_address stays 8, if_pc stays 8, if_instruction unchanged; after release, address 12, if_pc 12.
REQ-029 PC=0x10, branch_taken=1, branch_addr=0x42: next imem_address=0x40, IF/ID = {0,0,0} one cycle, then if_pc=0x44 with valid=1.
REQ-030 branch_taken=1 and freeze=1 together, branch_addr=0x20: PC becomes 0x20, IF/ID flushed (branch wins).
REQ-031 ADDR_LIMIT=72: after fetching address 68, imem_address=72, if_pc=72 valid=1 once, then valid=0 bubbles; branch to 0x3C returns to RUN, address 0x3C.
REQ-032 rst=1 for one cycle while PC=0x30: next cycle imem_address=RESET_PC, all IF/ID outputs 0.
